// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   NOP_INST       : word presented when no real instruction is available
//   ST_*           : fixed state encodings (kept stable for legacy tooling)
//   fetch_state_t  : fetch FSM state type built on those encodings
//   fetch_entry_t  : one buffered fetch result {pc, inst}
package inst_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   req/addr   : fetch request and word-aligned byte address (fetch side drives)
//   gnt        : request accepted this cycle (memory side drives)
//   rvalid/rdata : in-order response, at least one cycle after its grant
interface inst_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Small synchronous FIFO used for the fetch output buffer and the in-flight PC queue.
//   clk/rst     : clock, synchronous active-high reset
//   push/din    : write an entry (accepted when not full, or when popping the same cycle)
//   pop/dout    : remove the head; dout always shows the current head
//   flush       : empty the FIFO; overrides push/pop in the same cycle
//   count/full/empty : occupancy status
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter type         T     = fetch_entry_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  input  logic                         flush,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word requests to instruction memory, buffers
// returned words with their PC and presents them to decode/control. A taken
// redirect (PCSel on a consumed instruction) flushes the buffer and squashes
// every fetch still in flight.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   imem              : instruction-memory bus (master side)
//   stall_i           : downstream not consuming this cycle
//   PCSel_i, alu_i    : redirect request and target for the presented instruction
//   inst_valid_o      : inst_o/pc_o hold a real instruction
//   inst_o, pc_o, pc4_o : presented instruction, its PC, and PC+4
//   misalign_o        : one-cycle pulse when a redirect target was not word aligned
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  inst_fetch_unit_if.master        imem,
  input  logic                     stall_i,
  input  logic                     PCSel_i,
  input  logic [31:0]              alu_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              pc4_o,
  output logic                     misalign_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [CW-1:0] kill;
  logic [CW-1:0] kill_next;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] outstanding;
  logic [CW:0]   in_use;
  logic [31:0]   fetch_pc;
  logic [31:0]   flight_pc;
  fetch_entry_t  head;
  fetch_entry_t  ret_entry;
  logic          buf_full, buf_empty, pcq_full, pcq_empty;
  logic          redirect, room, grant, live_rv, kill_rv;

  assign inst_valid_o = !buf_empty;
  assign redirect     = PCSel_i & inst_valid_o & !stall_i;
  assign in_use       = {1'b0, buf_count} + {1'b0, outstanding};
  assign room         = !buf_full && !pcq_full && (in_use < (CW+1)'(DEPTH));
  assign imem.req     = (state == FETCH) && room && !redirect;
  assign imem.addr    = fetch_pc;
  assign grant        = imem.req & imem.gnt;
  assign kill_rv      = imem.rvalid & (kill != '0);
  assign live_rv      = imem.rvalid & (kill == '0);
  assign ret_entry    = '{pc: flight_pc, inst: imem.rdata};

  // Occupancy of the in-flight PC queue doubles as the outstanding-request count.
  fetch_fifo #(.T(logic [31:0]), .DEPTH(DEPTH)) u_pcq (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .din   (fetch_pc),
    .pop   (live_rv),
    .flush (redirect),
    .dout  (flight_pc),
    .count (outstanding),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (live_rv),
    .din   (ret_entry),
    .pop   (inst_valid_o & !stall_i),
    .flush (redirect),
    .dout  (head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // With nothing buffered, pc_o points at the next instruction expected to arrive.
  assign inst_o = inst_valid_o ? head.inst : NOP_INST;
  assign pc_o   = inst_valid_o ? head.pc : (pcq_empty ? fetch_pc : flight_pc);
  assign pc4_o  = pc_o + 32'd4;

  // On redirect every request still in flight becomes a response to discard; a
  // response arriving in the redirect cycle itself is dropped with the flush.
  always_comb begin
    kill_next = kill;
    if (redirect) begin
      kill_next = outstanding + CW'(grant) - CW'(live_rv);
    end else if (kill_rv) begin
      kill_next = kill - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (redirect && kill_next != '0) state_next = DRAIN;
      DRAIN:   if (kill_next == '0) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      kill       <= '0;
      fetch_pc   <= RESET_PC;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_next;
      kill       <= kill_next;
      misalign_o <= redirect & (alu_i[1:0] != 2'b00);
      if (redirect) begin
        fetch_pc <= {alu_i[31:2], 2'b00};
      end else if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b1;
  logic        PCSel_i = 1'b0;
  logic [31:0] alu_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o, pc_o, pc4_o;
  logic        misalign_o;

  inst_fetch_unit_if imem_bus ();

  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem         (imem_bus),
    .stall_i      (stall_i),
    .PCSel_i      (PCSel_i),
    .alu_i        (alu_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic redir; logic [31:0] target; } plan_t;
  typedef struct { logic [31:0] data; int unsigned due; } rsp_t;

  exp_t  sbq[$];    // expected architectural instruction stream
  plan_t planq[$];  // control decision for each instruction as it is consumed
  rsp_t  memq[$];   // memory stub: responses waiting to be returned

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;
  int unsigned reset_cyc = 0;
  int unsigned last_due = 0;
  int unsigned gnt_pct = 100, stall_pct = 0, lat_min = 1, lat_max = 1;
  int unsigned hold_stall = 0;
  logic        do_reset = 1'b0, in_reset = 1'b0, chk_latency = 1'b0;
  logic        exp_grant_valid = 1'b0, mis_exp = 1'b0;
  logic [31:0] exp_grant = '0;
  logic [31:0] model_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sequential PCs, a taken redirect continues at the aligned target.
  task automatic plan_one(input logic redir, input logic [31:0] target);
    exp_t e;
    plan_t p;
    e.pc = model_pc;
    e.inst = mem_word(model_pc);
    sbq.push_back(e);
    p.redir = redir;
    p.target = target;
    planq.push_back(p);
    model_pc = redir ? (target & 32'hFFFF_FFFC) : model_pc + 32'd4;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic wait_reset();
    int k = 0;
    do_reset = 1'b1;
    step(1);
    while ((do_reset || in_reset) && k < 10) begin
      step(1);
      k++;
    end
    if (do_reset || in_reset) begin
      checks++;
      $display("FAIL reset_timeout: reset sequence did not complete");
    end
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((planq.size() != 0 || sbq.size() != 0) && k < limit) begin
      step(1);
      k++;
    end
    if (sbq.size() != 0 || planq.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d instructions never presented", sbq.size());
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(4095);
    if ($urandom_range(7) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
    if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
    return t;
  endfunction

  // Driver and memory stub: acts at the falling edge, samples settled outputs #1 later.
  initial begin : driver
    plan_t p;
    rsp_t  r;
    logic  redir_now, last_stall;
    imem_bus.gnt = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (do_reset) begin
        rst_i = 1'b1;
        stall_i = 1'b1;
        PCSel_i = 1'b0;
        imem_bus.gnt = 1'b0;
        imem_bus.rvalid = 1'b0;
        memq.delete();
        planq.delete();
        sbq.delete();
        last_due = 0;
        model_pc = RESET_PC;
        exp_grant_valid = 1'b1;
        exp_grant = RESET_PC;
        mis_exp = 1'b0;
        hold_stall = 0;
        do_reset = 1'b0;
        in_reset = 1'b1;
      end else begin
        if (in_reset) begin
          check("rst_req", {31'd0, imem_bus.req}, 32'd0);
          check("rst_addr", imem_bus.addr, RESET_PC);
          check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
          check("rst_inst", inst_o, NOP_INST);
          check("rst_pc", pc_o, RESET_PC);
          check("rst_pc4", pc4_o, RESET_PC + 32'd4);
          check("rst_misalign", {31'd0, misalign_o}, 32'd0);
          rst_i = 1'b0;
          in_reset = 1'b0;
          reset_cyc = cyc;
        end
        if (memq.size() != 0 && memq[0].due <= cyc) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata = memq[0].data;
          void'(memq.pop_front());
        end else begin
          imem_bus.rvalid = 1'b0;
          imem_bus.rdata = $urandom;
        end
        imem_bus.gnt = ($urandom_range(99) < gnt_pct);
        redir_now = 1'b0;
        last_stall = 1'b0;
        if (hold_stall > 0) begin
          stall_i = 1'b1;
          last_stall = (hold_stall == 1);
          hold_stall--;
        end else if (planq.size() == 0) begin
          stall_i = 1'b1;
        end else begin
          stall_i = ($urandom_range(99) < stall_pct);
        end
        // PCSel noise while not consuming must be ignored by the DUT.
        PCSel_i = $urandom_range(1);
        alu_i = $urandom;
        if (inst_valid_o && !stall_i) begin
          p = planq.pop_front();
          PCSel_i = p.redir;
          alu_i = p.target;
          redir_now = p.redir;
        end
        if (chk_latency && inst_valid_o) begin
          check("first_valid_cycle", cyc - reset_cyc, 32'd3);
          chk_latency = 1'b0;
        end
        #1;
        check("misalign", {31'd0, misalign_o}, {31'd0, mis_exp});
        if (redir_now) check("req_on_redirect", {31'd0, imem_bus.req}, 32'd0);
        if (last_stall) check("req_while_full", {31'd0, imem_bus.req}, 32'd0);
        if (imem_bus.req && imem_bus.gnt) begin
          if (exp_grant_valid) begin
            check("first_addr_after_redirect", imem_bus.addr, exp_grant);
            exp_grant_valid = 1'b0;
          end
          check("addr_align", {30'd0, imem_bus.addr[1:0]}, 32'd0);
          r.data = mem_word(imem_bus.addr);
          r.due = cyc + $urandom_range(lat_max, lat_min);
          if (r.due <= last_due) r.due = last_due + 1;
          last_due = r.due;
          memq.push_back(r);
        end
        mis_exp = redir_now && (alu_i[1:0] != 2'b00);
        if (redir_now) begin
          exp_grant_valid = 1'b1;
          exp_grant = alu_i & 32'hFFFF_FFFC;
        end
      end
    end
  end

  // Monitor: compares every consumed instruction against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i) begin
        if (inst_valid_o && !stall_i) begin
          if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_inst: pc %h inst %h with nothing expected", pc_o, inst_o);
          end else begin
            e = sbq.pop_front();
            check("pc", pc_o, e.pc);
            check("inst", inst_o, e.inst);
            check("pc4", pc4_o, e.pc + 32'd4);
          end
        end else if (!inst_valid_o) begin
          check("nop_when_empty", inst_o, NOP_INST);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

  initial begin : main
    // Straight-line fetch: grant always, 1-cycle memory, no stalls.
    gnt_pct = 100; stall_pct = 0; lat_min = 1; lat_max = 1;
    chk_latency = 1'b1;
    wait_reset();
    repeat (6) plan_one(1'b0, '0);
    wait_drain(200);

    // Downstream stall held 5 cycles with the buffer filling behind it.
    repeat (8) plan_one(1'b0, '0);
    step(2);
    hold_stall = 5;
    wait_drain(200);

    // Redirect at pc 8 to 0x100 with slow memory so requests are in flight.
    lat_min = 3; lat_max = 3;
    wait_reset();
    plan_one(1'b0, '0);
    plan_one(1'b0, '0);
    plan_one(1'b1, 32'h0000_0100);
    repeat (4) plan_one(1'b0, '0);
    wait_drain(300);

    // Misaligned target, then a target that wraps past the top of memory.
    plan_one(1'b1, 32'h0000_0106);
    repeat (3) plan_one(1'b0, '0);
    wait_drain(300);
    plan_one(1'b1, 32'hFFFF_FFF8);
    repeat (4) plan_one(1'b0, '0);
    wait_drain(300);

    // Random handshakes, latencies and redirects.
    gnt_pct = 70; stall_pct = 30; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(99) < 15) plan_one(1'b1, rand_target());
      else plan_one(1'b0, '0);
    end
    wait_drain(5000);

    // Reset in the middle of a busy stream, then fetch restarts from RESET_PC.
    gnt_pct = 100; stall_pct = 0; lat_min = 3; lat_max = 3;
    repeat (20) plan_one(1'b0, '0);
    step(8);
    wait_reset();
    repeat (5) plan_one(1'b0, '0);
    wait_drain(300);

    step(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
